// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO write port among
// NUM_REQ byte-stream requesters, with an optional requester-ID header byte.
module uart_tx_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter bit         HDR_EN  = 1'b1,
  parameter logic [3:0] HDR_TAG = 4'hA,
  parameter int         MAX_PKT = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ-1:0]   req_en,
  output logic                 wrvalid,
  input  logic                 wrready,
  output logic [7:0]           wrdata,
  output logic [3:0]           grant_id,
  output logic                 busy,
  output logic                 err_len
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t             state, state_nxt;
  logic [3:0]         last_grant;
  logic [7:0]         count;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [3:0]         pick_id;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               xfer;

  // Round-robin search starting one past the last granted requester.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    eligible = req_valid & req_en;
    found    = 1'b0;
    pick_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && eligible[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          found   = 1'b1;
          pick_id = 4'(i);
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 4'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wrvalid   = 1'b0;
    wrdata    = '0;
    req_ready = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_nxt = HDR_EN ? HDR : DATA;
      end
      HDR: begin
        wrvalid = 1'b1;
        wrdata  = {HDR_TAG, grant_id};
        if (wrready) state_nxt = DATA;
      end
      DATA: begin
        // Zero-latency pass-through of the granted requester.
        wrvalid = sel_valid;
        wrdata  = sel_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id == 4'(i)) && wrready;
        end
        xfer = sel_valid && wrready;
        if (xfer && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_id   <= '0;
      last_grant <= 4'(NUM_REQ - 1);
      count      <= '0;
      err_len    <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        grant_id <= pick_id;
        count    <= '0;
      end
      if (xfer) begin
        count <= (count == 8'hFF) ? count : count + 8'd1;
        // Packet already holds MAX_PKT bytes; flag it but keep forwarding.
        if ({1'b0, count} == 9'(MAX_PKT)) err_len <= 1'b1;
        if (sel_last) last_grant <= grant_id;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters and a byte/grant
// scoreboard checked on every FIFO write transfer.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXP = 4;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_en;
  logic           wrvalid;
  logic           wrready;
  logic [7:0]     wrdata;
  logic [3:0]     grant_id;
  logic           busy;
  logic           err_len;

  uart_tx_arbiter #(
    .NUM_REQ(N), .HDR_EN(1'b1), .HDR_TAG(4'hA), .MAX_PKT(MAXP)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_last(req_last), .req_en(req_en),
    .wrvalid(wrvalid), .wrready(wrready), .wrdata(wrdata),
    .grant_id(grant_id), .busy(busy), .err_len(err_len)
  );

  always #5 aclk = ~aclk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];
  logic [3:0] grant_q [$];
  int         sent_cnt [N];
  logic       wr_rdy;
  logic [N-1:0] en_mask;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_busy;
  int         idle_run;
  bit         seen_grant;
  bit         chk_gap;
  logic [N-1:0] xfer_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] head;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        head               = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = head[7:0];
        req_last[i]        = head[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    req_en  = en_mask;
    wrready = wr_rdy;
  endtask

  task automatic add_src(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
    drive();
  endtask

  task automatic exp_hdr(input int id);
    exp_q.push_back({4'hA, 4'(id)});
    grant_q.push_back(4'(id));
  endtask

  function automatic int src_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += src_q[i].size();
    return t;
  endfunction

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      sent_cnt[i] = 0;
    end
    exp_q.delete();
    grant_q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_busy  = 1'b0;
    idle_run   = 0;
    seen_grant = 1'b0;
  endtask

  // One clock: monitor at negedge, then pop accepted source bytes and re-drive.
  task automatic tick();
    logic [7:0]   e;
    logic [3:0]   g;
    logic [8:0]   junk;
    logic [N-1:0] one = 1;
    @(negedge aclk);
    if (prev_stall) begin
      check("hold_valid", wrvalid, 1);
      check("hold_data", wrdata, prev_data);
    end
    if (!wrready) check("ready_gated", req_ready, 0);
    check("ready_onehot", req_ready & ~(one << grant_id), 0);
    if (busy && !prev_busy) begin
      if (grant_q.size() == 0) check("grant_pending", grant_q.size(), 1);
      else begin
        g = grant_q.pop_front();
        check("grant_id", grant_id, g);
      end
      if (chk_gap && seen_grant) check("idle_gap", idle_run, 1);
      seen_grant = 1'b1;
    end
    idle_run = busy ? 0 : idle_run + 1;
    if (wrvalid && wrready) begin
      if (exp_q.size() == 0) check("byte_pending", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("wrdata", wrdata, e);
      end
    end
    prev_stall = wrvalid && !wrready;
    prev_data  = wrdata;
    prev_busy  = busy;
    xfer_req   = req_valid & req_ready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer_req[i]) begin
        junk = src_q[i].pop_front();
        sent_cnt[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    flush();
    wr_rdy  = 1'b1;
    en_mask = '1;
    drive();
    repeat (2) @(posedge aclk);
    #1;
    check("rst_wrvalid", wrvalid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_len, 0);
    check("rst_grant", grant_id, 0);
    aresetn = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || grant_q.size() != 0 || src_total() != 0 || busy) && n < bound) begin
      tick();
      n++;
    end
    check("drain_bytes", exp_q.size(), 0);
    check("drain_grants", grant_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic run_until_src_empty(input int id, input int bound);
    int n = 0;
    while (src_q[id].size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("src_empty", src_q[id].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         n;
    req_valid = '0; req_data = '0; req_last = '0; req_en = '0; wrready = 1'b0;
    chk_gap = 1'b0;

    // Arbitration order with headers
    do_reset();
    chk_gap = 1'b1;
    exp_hdr(0); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_hdr(2); exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    add_src(0, 8'h11, 0); add_src(0, 8'h22, 0); add_src(0, 8'h33, 1);
    add_src(2, 8'h44, 0); add_src(2, 8'h55, 0); add_src(2, 8'h66, 1);
    drain(60);
    tick(); tick();
    check("grant_hold_idle", grant_id, 2);

    // Fairness: four requesters, back-to-back single-byte packets
    do_reset();
    chk_gap = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        d = 8'(16 * i + r + 1);
        exp_hdr(i);
        exp_q.push_back(d);
        add_src(i, d, 1);
      end
    end
    drain(100);

    // Backpressure in HDR and mid-DATA
    do_reset();
    chk_gap = 1'b0;
    exp_hdr(2); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    wr_rdy = 1'b0;
    add_src(2, 8'hC1, 0); add_src(2, 8'hC2, 0); add_src(2, 8'hC3, 1);
    repeat (6) tick();
    check("bp_hdr_valid", wrvalid, 1);
    check("bp_hdr_data", wrdata, 8'hA2);
    check("bp_hdr_ready", req_ready, 0);
    check("bp_hdr_sent", sent_cnt[2], 0);
    wr_rdy = 1'b1; drive();
    repeat (2) tick();
    check("bp_first_sent", sent_cnt[2], 1);
    wr_rdy = 1'b0; drive();
    repeat (3) tick();
    check("bp_data_valid", wrvalid, 1);
    check("bp_data_byte", wrdata, 8'hC2);
    check("bp_data_sent", sent_cnt[2], 1);
    wr_rdy = 1'b1; drive();
    drain(40);
    check("bp_total_sent", sent_cnt[2], 3);

    // Grant lock while requester 1 stalls; requester 3 masked at next decision
    do_reset();
    exp_hdr(1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    exp_hdr(0); exp_q.push_back(8'hD0);
    exp_hdr(3); exp_q.push_back(8'hE0); exp_q.push_back(8'hE1);
    add_src(1, 8'hB0, 0); add_src(1, 8'hB1, 0);
    run_until_src_empty(1, 20);
    add_src(3, 8'hE0, 0); add_src(3, 8'hE1, 1); add_src(0, 8'hD0, 1);
    repeat (4) begin
      tick();
      check("lock_wrvalid", wrvalid, 0);
      check("lock_grant", grant_id, 1);
      check("lock_busy", busy, 1);
    end
    en_mask[3] = 1'b0;
    add_src(1, 8'hB2, 0); add_src(1, 8'hB3, 1);
    run_until_src_empty(0, 30);
    check("lock_req3_waiting", sent_cnt[3], 0);
    en_mask[3] = 1'b1; drive();
    drain(40);
    check("lock_req3_sent", sent_cnt[3], 2);

    // Length overrun: six payload bytes against MAX_PKT = 4
    do_reset();
    exp_hdr(0);
    for (int b = 0; b < 6; b++) begin
      d = 8'(8'h70 + b);
      exp_q.push_back(d);
      add_src(0, d, b == 5);
    end
    n = 0;
    while (src_q[0].size() != 0 && n < 40) begin
      check("len_err", err_len, sent_cnt[0] >= 5);
      tick();
      n++;
    end
    check("len_src_empty", src_q[0].size(), 0);
    check("len_err_set", err_len, 1);
    drain(20);
    repeat (3) tick();
    check("len_err_sticky", err_len, 1);
    check("len_sent", sent_cnt[0], 6);

    // Asynchronous reset during DATA byte 2
    exp_hdr(2);
    for (int b = 0; b < 4; b++) begin
      d = 8'(8'h90 + b);
      exp_q.push_back(d);
      add_src(2, d, b == 3);
    end
    n = 0;
    while (sent_cnt[2] < 1 && n < 20) begin
      tick();
      n++;
    end
    check("rstmid_reached", sent_cnt[2], 1);
    #2 aresetn = 1'b0;
    #1;
    check("rstmid_wrvalid", wrvalid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_err", err_len, 0);
    check("rstmid_ready", req_ready, 0);
    flush();
    drive();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    exp_hdr(0); exp_q.push_back(8'hF0);
    exp_hdr(3); exp_q.push_back(8'hF3);
    add_src(3, 8'hF3, 1); add_src(0, 8'hF0, 1);
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
